// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ command ports onto one Avalon-MM master.
// One transaction outstanding at a time; reads complete with data or a timeout error.
module sdram_port_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic [ADDR_W-1:0]         avm_address,
   output logic [DATA_W-1:0]         avm_writedata,
   output logic                      avm_read,
   output logic                      avm_write,
   input  logic                      avm_waitrequest,
   input  logic                      avm_readdatavalid,
   input  logic [DATA_W-1:0]         avm_readdata,
   output logic                      busy
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] CMD    = 2'd1;
   localparam logic [1:0] RDWAIT = 2'd2;

   logic [1:0]         state;
   logic [IDX_W-1:0]   last_grant;
   logic [IDX_W-1:0]   grant;
   logic [IDX_W-1:0]   next_grant;
   logic               any_req;
   logic               wr_q;
   logic [15:0]        tmo_cnt;
   logic [NUM_REQ-1:0] grant_oh;
   logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

   always_comb begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         addr_arr[k]  = req_addr[k*ADDR_W +: ADDR_W];
         wdata_arr[k] = req_wdata[k*DATA_W +: DATA_W];
      end
   end

   // Search starts one past the last winner so a re-requester goes to the back.
   always_comb begin
      int unsigned cand;
      cand       = '0;
      any_req    = 1'b0;
      next_grant = last_grant;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = 32'(last_grant) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!any_req && req_valid[IDX_W'(cand)]) begin
            any_req    = 1'b1;
            next_grant = IDX_W'(cand);
         end
      end
   end

   assign grant_oh  = NUM_REQ'(1) << grant;
   assign req_ready = (state == CMD && !avm_waitrequest) ? grant_oh : '0;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state         <= IDLE;
         last_grant    <= IDX_W'(NUM_REQ - 1);
         grant         <= '0;
         wr_q          <= 1'b0;
         tmo_cnt       <= '0;
         avm_read      <= 1'b0;
         avm_write     <= 1'b0;
         avm_address   <= '0;
         avm_writedata <= '0;
         rsp_valid     <= '0;
         rsp_rdata     <= '0;
         rsp_err       <= 1'b0;
      end else begin
         rsp_valid <= '0;
         rsp_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  state         <= CMD;
                  grant         <= next_grant;
                  last_grant    <= next_grant;
                  wr_q          <= req_write[next_grant];
                  avm_address   <= addr_arr[next_grant];
                  avm_writedata <= wdata_arr[next_grant];
                  avm_read      <= !req_write[next_grant];
                  avm_write     <= req_write[next_grant];
               end
            end
            CMD: begin
               if (!avm_waitrequest) begin
                  avm_read  <= 1'b0;
                  avm_write <= 1'b0;
                  tmo_cnt   <= '0;
                  state     <= wr_q ? IDLE : RDWAIT;
               end
            end
            RDWAIT: begin
               // Returned data takes priority over a timeout expiring in the same cycle.
               if (avm_readdatavalid) begin
                  rsp_valid <= grant_oh;
                  rsp_rdata <= avm_readdata;
                  state     <= IDLE;
               end else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
                  rsp_valid <= grant_oh;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  state     <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: transaction-level reference model predicts
// grants and completions; a monitor compares whenever the DUT presents a handshake.
module tb_sdram_port_arbiter;
   localparam int unsigned N   = 3;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 4;

   logic            clk_clk = 1'b0;
   logic            reset_reset_n = 1'b0;
   logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata, avm_writedata, avm_readdata;
   logic [AW-1:0]   avm_address;
   logic            rsp_err, avm_read, avm_write, avm_waitrequest, avm_readdatavalid, busy;

   sdram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .avm_address(avm_address), .avm_writedata(avm_writedata),
      .avm_read(avm_read), .avm_write(avm_write),
      .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
      .avm_readdata(avm_readdata), .busy(busy)
   );

   always #5 clk_clk = ~clk_clk;

   typedef struct { int idx; bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } cmd_t;
   typedef struct { int idx; logic [DW-1:0] data; bit err; int cyc; } rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];
   int   acc_log[$];
   int   checks = 0, errors = 0, cyc = 0, rsp_count = 0;
   logic [DW-1:0] last_rsp_data;
   logic          last_rsp_err;

   // Reference model state: who holds the port and what it is waiting for.
   bit          in_reset = 1'b1, drive_en = 1'b0;
   int          rr_last = N - 1;
   int          stage = 0;      // 0 free, 1 waiting for acceptance, 2 waiting for read data
   int          cur_idx = 0, wait_cnt = 0;
   bit          cur_wr;
   bit [N-1:0]  acc_now = '0;

   always @(posedge clk_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk_clk);
      #1;
   endtask

   task automatic new_cmd(input int i);
      req_valid[i] = 1'b1;
      req_write[i] = 1'($urandom_range(1));
      req_addr[i*AW +: AW]  = $urandom;
      req_wdata[i*DW +: DW] = $urandom;
   endtask

   task automatic check_reset_outputs();
      chk("rst_avm_read", avm_read, 0);
      chk("rst_avm_write", avm_write, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_avm_address", avm_address, 0);
      chk("rst_avm_writedata", avm_writedata, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
   endtask

   always @(negedge clk_clk) begin : ref_model
      int c;
      bit found;
      acc_now = '0;
      found   = 1'b0;
      if (in_reset) begin
         stage   = 0;
         rr_last = N - 1;
      end else if (stage == 0) begin
         for (int k = 1; k <= N; k++) begin
            c = (rr_last + k) % N;
            if (!found && req_valid[c]) begin
               found   = 1'b1;
               cur_idx = c;
               cur_wr  = req_write[c];
               rr_last = c;
               stage   = 1;
               cmd_q.push_back('{c, req_write[c], req_addr[c*AW +: AW], req_wdata[c*DW +: DW], cyc});
            end
         end
      end else if (stage == 1) begin
         if (!avm_waitrequest) begin
            acc_now[cur_idx] = 1'b1;
            stage    = cur_wr ? 0 : 2;
            wait_cnt = 0;
         end
      end else begin
         if (avm_readdatavalid) begin
            rsp_q.push_back('{cur_idx, avm_readdata, 1'b0, cyc + 1});
            stage = 0;
         end else begin
            wait_cnt++;
            if (wait_cnt == TMO) begin
               rsp_q.push_back('{cur_idx, '0, 1'b1, cyc + 1});
               stage = 0;
            end
         end
      end
   end

   initial begin : monitor
      logic strobe, prev_strobe;
      cmd_t e;
      rsp_t r;
      prev_strobe = 1'b0;
      forever begin
         @(negedge clk_clk);
         #1;
         strobe = avm_read | avm_write;
         if (strobe && !prev_strobe) begin
            checks++;
            if (cmd_q.size() == 0) begin
               errors++;
               $display("FAIL strobe_unexpected: got strobe at cycle %0d, required none", cyc);
            end else chk("strobe_latency", cyc, cmd_q[0].cyc + 1);
         end
         if (req_ready != '0 || (strobe && !avm_waitrequest)) begin
            checks++;
            if (cmd_q.size() == 0) begin
               errors++;
               $display("FAIL accept_unexpected: got req_ready=%b at cycle %0d, required none", req_ready, cyc);
            end else begin
               e = cmd_q.pop_front();
               chk("req_ready", req_ready, 1 << e.idx);
               chk("avm_write", avm_write, e.wr);
               chk("avm_read", avm_read, !e.wr);
               chk("avm_address", avm_address, e.addr);
               chk("avm_writedata", avm_writedata, e.data);
               chk("busy", busy, 1);
               for (int i = 0; i < N; i++) if (req_ready[i]) acc_log.push_back(i);
            end
         end
         if (rsp_valid != '0) begin
            checks++;
            rsp_count++;
            last_rsp_data = rsp_rdata;
            last_rsp_err  = rsp_err;
            if (rsp_q.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: got rsp_valid=%b at cycle %0d, required none", rsp_valid, cyc);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_valid", rsp_valid, 1 << r.idx);
               chk("rsp_rdata", rsp_rdata, r.data);
               chk("rsp_err", rsp_err, r.err);
               chk("rsp_cycle", cyc, r.cyc);
            end
         end
         prev_strobe = strobe;
      end
   end

   // Random requesters and slave; a granted requester may drop or scramble its payload.
   initial begin : driver
      forever begin
         @(posedge clk_clk);
         #1;
         if (drive_en) begin
            avm_waitrequest   = ($urandom_range(99) < 40);
            avm_readdatavalid = ($urandom_range(99) < 30);
            avm_readdata      = $urandom;
            for (int i = 0; i < N; i++) begin
               if (acc_now[i] || !req_valid[i]) begin
                  if ($urandom_range(99) < 50) new_cmd(i);
                  else req_valid[i] = 1'b0;
               end else if (stage == 1 && cur_idx == i) begin
                  if ($urandom_range(99) < 15) req_valid[i] = 1'b0;
                  else if ($urandom_range(99) < 25) new_cmd(i);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int exp_order[4];
      int saved, k;
      bit hit;
      exp_order = '{0, 1, 2, 0};
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
      cycles(2);
      check_reset_outputs();

      // All requesters writing from reset, slave never stalls.
      req_valid = '1; req_write = '1;
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW]  = 32'h1000 * (i + 1);
         req_wdata[i*DW +: DW] = $urandom;
      end
      reset_reset_n = 1'b1; in_reset = 1'b0;
      cycles(12);
      req_valid = '0;
      cycles(4);
      checks++;
      if (acc_log.size() < 4) begin
         errors++;
         $display("FAIL grant_order: got %0d grants, required at least 4", acc_log.size());
      end else for (int i = 0; i < 4; i++) chk("grant_order", acc_log[i], exp_order[i]);

      // Requester 1 read 0x100: 3 stalled cycles, data two cycles after acceptance.
      avm_waitrequest = 1'b1;
      req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[AW +: AW] = 32'h100;
      saved = rsp_count;
      cycles(4);
      avm_waitrequest = 1'b0;
      cycles(1);
      avm_waitrequest = 1'b1; req_valid[1] = 1'b0;
      cycles(1);
      avm_readdatavalid = 1'b1; avm_readdata = 32'hCAFEF00D;
      cycles(1);
      avm_readdatavalid = 1'b0; avm_readdata = '0; avm_waitrequest = 1'b0;
      cycles(2);
      chk("read_rsp_count", rsp_count, saved + 1);
      chk("read_rdata", last_rsp_data, 32'hCAFEF00D);
      chk("read_err", last_rsp_err, 0);

      // Requester 0 read with no data: timeout completion, then a late response.
      req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0 +: AW] = 32'h40;
      saved = rsp_count;
      cycles(2);
      req_valid[0] = 1'b0;
      cycles(8);
      chk("tmo_rsp_count", rsp_count, saved + 1);
      chk("tmo_err", last_rsp_err, 1);
      chk("tmo_rdata", last_rsp_data, 0);
      avm_readdatavalid = 1'b1; avm_readdata = 32'h12345678;
      cycles(2);
      avm_readdatavalid = 1'b0;
      cycles(2);
      chk("late_rdv_ignored", rsp_count, saved + 1);

      // Requester 2 write 0x20 / 0x55AA55AA.
      req_valid[2] = 1'b1; req_write[2] = 1'b1;
      req_addr[2*AW +: AW] = 32'h20; req_wdata[2*DW +: DW] = 32'h55AA55AA;
      saved = rsp_count;
      cycles(1);
      chk("wr_strobe", avm_write, 1);
      chk("wr_addr", avm_address, 32'h20);
      chk("wr_data", avm_writedata, 32'h55AA55AA);
      chk("wr_ready", req_ready, 3'b100);
      cycles(1);
      req_valid[2] = 1'b0;
      cycles(4);
      chk("wr_no_rsp", rsp_count, saved);

      // Requester 0 drops req_valid while its command is stalled.
      avm_waitrequest = 1'b1;
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0 +: AW] = 32'h80;
      cycles(1);
      req_valid[0] = 1'b0;
      cycles(2);
      chk("drop_stalled", req_ready, 0);
      avm_waitrequest = 1'b0;
      #1;
      chk("drop_ready", req_ready, 3'b001);
      cycles(3);

      drive_en = 1'b1;
      cycles(600);

      // Reset while a read is waiting for data.
      hit = 1'b0; k = 0;
      while (!hit && k < 400) begin
         @(negedge clk_clk);
         k++;
         if (stage == 2 && wait_cnt >= 1) hit = 1'b1;
      end
      chk("rdwait_reached", hit, 1);
      if (hit) begin
         #2;
         reset_reset_n = 1'b0; in_reset = 1'b1;
         cmd_q.delete(); rsp_q.delete();
         stage = 0; rr_last = N - 1; acc_now = '0;
         #1;
         check_reset_outputs();
         cycles(2);
         #1;
         reset_reset_n = 1'b1; in_reset = 1'b0;
      end

      cycles(600);
      drive_en = 1'b0;
      @(posedge clk_clk);
      #2;
      req_valid = '0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
      cycles(20);
      chk("cmd_q_drained", cmd_q.size(), 0);
      chk("rsp_q_drained", rsp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
